// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the muon-lifetime TDC sequencer:
//   - tdc_state_t   : sequencer states (IDLE, RUN, HOLD)
//   - default widths and timing constants
//   - TDC_OVERFLOW(): all-ones result code for a given counter width
// -----------------------------------------------------------------------------
package tdc_pkg;

    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_STAT_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 120;
    localparam int DEF_DEAD_CYCLES    = 16;

    // Widest interval counter TDC_OVERFLOW can describe.
    localparam int MAX_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } tdc_state_t;

    // All-ones in the low 'width' bits: the result code reported on timeout.
    function automatic logic [MAX_CNT_WIDTH-1:0] TDC_OVERFLOW(input int width);
        logic [MAX_CNT_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_CNT_WIDTH; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/tdc_ctrl_if.sv
// -----------------------------------------------------------------------------
// tdc_ctrl_if
// Bundles the TDC sequencer's control inputs, result outputs and statistics.
//   master : the upstream/system side (drives enable, pulses, clear_stats)
//   slave  : the tdc_ctrl side (drives result, flags, statistics, dbg_state)
//
// Signal semantics: start_pulse and stop_pulse are single-cycle event strobes
// with no back-pressure; result_valid is a one-cycle strobe marking the cycle
// in which result/timeout take a new value, and result/timeout stay stable
// until the next strobe. There is no ready signal: the consumer must sample
// result whenever result_valid is high.
// -----------------------------------------------------------------------------
interface tdc_ctrl_if
    import tdc_pkg::*;
#(
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int STAT_WIDTH = DEF_STAT_WIDTH
) ();

    logic                  enable;
    logic                  start_pulse;
    logic                  stop_pulse;
    logic                  clear_stats;

    logic [CNT_WIDTH-1:0]  result;
    logic                  result_valid;
    logic                  timeout;
    logic                  busy;
    logic [STAT_WIDTH-1:0] n_starts;
    logic [STAT_WIDTH-1:0] n_stops;
    logic [STAT_WIDTH-1:0] n_timeouts;

    // Current sequencer state, for observation only.
    tdc_state_t            dbg_state;

    modport master (
        output enable, start_pulse, stop_pulse, clear_stats,
        input  result, result_valid, timeout, busy,
        input  n_starts, n_stops, n_timeouts, dbg_state
    );

    modport slave (
        input  enable, start_pulse, stop_pulse, clear_stats,
        output result, result_valid, timeout, busy,
        output n_starts, n_stops, n_timeouts, dbg_state
    );

endinterface

// File: rtl/tdc_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating event counter used for the TDC statistics.
//   clk   : clock
//   rst   : synchronous active-high reset
//   inc   : count one event this cycle
//   clr   : synchronous clear; wins over a coincident inc
//   count : current value, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tdc_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_ctrl
// Sequencer for the muon-lifetime time-to-digital measurement. An accepted
// start_pulse arms the interval counter; a stop_pulse latches the interval,
// or after TIMEOUT_CYCLES an all-ones result with the timeout flag is issued.
// Every result is followed by DEAD_CYCLES of HOLD before re-arming.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : tdc_ctrl_if.slave (enable, start/stop pulses, clear_stats in;
//          result, result_valid, timeout, busy, n_starts, n_stops,
//          n_timeouts, dbg_state out)
//
// Build option:
//   TDC_RETRIGGER_EN : when defined, a start_pulse during RUN restarts the
//                      measurement (count=1, n_starts+1, no result for the
//                      abandoned start). When undefined it is ignored.
// -----------------------------------------------------------------------------
module tdc_ctrl
    import tdc_pkg::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES, // < 2**CNT_WIDTH-1
    parameter int DEAD_CYCLES    = DEF_DEAD_CYCLES,    // >= 1
    parameter int STAT_WIDTH     = DEF_STAT_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    tdc_ctrl_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] OVERFLOW    = CNT_WIDTH'(TDC_OVERFLOW(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam int                   DEAD_W      = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0]    DEAD_LAST   = DEAD_W'(DEAD_CYCLES - 1);

    tdc_state_t           state;
    logic [CNT_WIDTH-1:0] count;
    logic [DEAD_W-1:0]    dead_cnt;
    logic [CNT_WIDTH-1:0] result_q;
    logic                 result_valid_q;
    logic                 timeout_q;
    logic                 busy_q;

    // Per-cycle decisions, shared by the FSM and the statistics counters so
    // both always agree on what was accepted.
    logic start_acc;   // start accepted in IDLE
    logic restart;     // start accepted in RUN (retrigger build only)
    logic stop_acc;    // valid measurement completes
    logic to_acc;      // measurement times out

    always_comb begin
        start_acc = 1'b0;
        restart   = 1'b0;
        stop_acc  = 1'b0;
        to_acc    = 1'b0;
        // enable low overrides everything: nothing is accepted or counted.
        if (bus.enable) begin
            case (state)
                IDLE: begin
                    start_acc = bus.start_pulse;
                end
                RUN: begin
                    // A stop in the same cycle as count==TIMEOUT_VAL is still
                    // a valid measurement, so stop is checked first.
                    if (bus.stop_pulse) begin
                        stop_acc = 1'b1;
`ifdef TDC_RETRIGGER_EN
                    end else if (bus.start_pulse) begin
                        restart = 1'b1;
`endif
                    end else if (count == TIMEOUT_VAL) begin
                        to_acc = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            dead_cnt       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (!bus.enable) begin
                // Abandon any measurement; result and timeout keep their values.
                state    <= IDLE;
                count    <= '0;
                dead_cnt <= '0;
                busy_q   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_acc) begin
                            state  <= RUN;
                            count  <= CNT_WIDTH'(1);
                            busy_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop_acc) begin
                            result_q       <= count;
                            timeout_q      <= 1'b0;
                            result_valid_q <= 1'b1;
                            state          <= HOLD;
                            dead_cnt       <= '0;
                        end else if (restart) begin
                            count <= CNT_WIDTH'(1);
                        end else if (to_acc) begin
                            result_q       <= OVERFLOW;
                            timeout_q      <= 1'b1;
                            result_valid_q <= 1'b1;
                            state          <= HOLD;
                            dead_cnt       <= '0;
                        end else begin
                            // Never passes TIMEOUT_VAL, so it cannot wrap.
                            count <= count + CNT_WIDTH'(1);
                        end
                    end
                    HOLD: begin
                        // dead_cnt runs 0..DEAD_LAST: exactly DEAD_CYCLES cycles in HOLD.
                        if (dead_cnt == DEAD_LAST) begin
                            state  <= IDLE;
                            count  <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            dead_cnt <= dead_cnt + DEAD_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        count  <= '0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.WIDTH(STAT_WIDTH)) u_starts (
        .clk   (clk),
        .rst   (rst),
        .inc   (start_acc | restart),
        .clr   (bus.clear_stats),
        .count (bus.n_starts)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_stops (
        .clk   (clk),
        .rst   (rst),
        .inc   (stop_acc),
        .clr   (bus.clear_stats),
        .count (bus.n_stops)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_timeouts (
        .clk   (clk),
        .rst   (rst),
        .inc   (to_acc),
        .clr   (bus.clear_stats),
        .count (bus.n_timeouts)
    );

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = busy_q;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_tdc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_ctrl
// Self-checking bench for tdc_ctrl (default build). Each measurement is
// described by event offsets relative to the accepted start edge; the
// expected outcome (which result, at which offset, busy span, statistics)
// is worked out arithmetically from those offsets.
// -----------------------------------------------------------------------------
module tb_tdc_ctrl;
    import tdc_pkg::*;

    localparam int TO      = 120;
    localparam int DEAD    = 16;
    localparam int RUN_LEN = 160;   // covers f+DEAD and late stops up to 140

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Reference model state
    logic [15:0] m_res;
    logic        m_to;
    int          m_starts;
    int          m_stops;
    int          m_touts;

    tdc_ctrl_if bus ();

    tdc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver + model for one measurement ----------------
    // Offsets are edges relative to the start edge (offset 0); -1 = never.
    task automatic run_one(input string name, input int stop_at, input int drop_at,
                           input int clear_at, input bit co_stop, input int noise_at);
        bit   stop_ok;
        int   f;
        bit   disc;
        int   busy_end;
        int   nv;
        int   v_off;
        logic [15:0] v_res;
        logic v_to;
        bit   busy_bad;
        bit   exp_busy;
        bit   starts_cnt, stops_cnt, touts_cnt;

        // Expected outcome from the measurement rules.
        stop_ok  = (stop_at >= 1) && (stop_at <= TO);
        f        = stop_ok ? stop_at : TO;
        disc     = (drop_at >= 1) && (drop_at <= f);
        busy_end = f + DEAD;
        if (drop_at >= 1 && drop_at < busy_end) busy_end = drop_at;

        nv = 0; v_off = -1; v_res = '0; v_to = 1'b0; busy_bad = 1'b0;
        for (int k = 0; k <= RUN_LEN; k++) begin
            bus.start_pulse = (k == 0) || (k == noise_at);
            bus.stop_pulse  = (k == stop_at) || (k == 0 && co_stop);
            bus.enable      = !(drop_at >= 1 && k >= drop_at);
            bus.clear_stats = (k == clear_at);
            step();
            if (bus.result_valid === 1'b1) begin
                nv++;
                v_off = k;
                v_res = bus.result;
                v_to  = bus.timeout;
            end
            exp_busy = (k < busy_end);
            if (bus.busy !== exp_busy) busy_bad = 1'b1;
        end
        bus.start_pulse = 1'b0;
        bus.stop_pulse  = 1'b0;
        bus.clear_stats = 1'b0;
        bus.enable      = 1'b1;

        // Statistics: a coincident clear wins, so only events after it survive.
        starts_cnt = 1'b1;
        stops_cnt  = !disc && stop_ok;
        touts_cnt  = !disc && !stop_ok;
        if (clear_at >= 0) begin
            m_starts = 0; m_stops = 0; m_touts = 0;
            starts_cnt = starts_cnt && (0 > clear_at);
            stops_cnt  = stops_cnt  && (f > clear_at);
            touts_cnt  = touts_cnt  && (f > clear_at);
        end
        m_starts += int'(starts_cnt);
        m_stops  += int'(stops_cnt);
        m_touts  += int'(touts_cnt);
        if (!disc) begin
            m_res = stop_ok ? 16'(f) : 16'hFFFF;
            m_to  = !stop_ok;
        end

        check({name, ".n_valid"}, nv, disc ? 0 : 1);
        if (!disc) begin
            check({name, ".valid_offset"}, v_off, f);
            check({name, ".strobe_result"}, v_res, m_res);
            check({name, ".strobe_timeout"}, v_to, m_to);
        end
        check({name, ".busy_span"}, busy_bad, 0);
        check({name, ".result"}, bus.result, m_res);
        check({name, ".timeout"}, bus.timeout, m_to);
        check({name, ".n_starts"}, bus.n_starts, m_starts);
        check({name, ".n_stops"}, bus.n_stops, m_stops);
        check({name, ".n_timeouts"}, bus.n_timeouts, m_touts);
        check({name, ".idle"}, bus.dbg_state, IDLE);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int s, d, c, n;
        bit co;

        total = 0; bad = 0;
        m_res = '0; m_to = 1'b0; m_starts = 0; m_stops = 0; m_touts = 0;

        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.start_pulse = 1'b1;
        bus.stop_pulse  = 1'b1;
        bus.clear_stats = 1'b0;
        repeat (3) step();
        rst             = 1'b0;
        bus.start_pulse = 1'b0;
        bus.stop_pulse  = 1'b0;
        step();

        check("reset.state", bus.dbg_state, IDLE);
        check("reset.result", bus.result, 0);
        check("reset.result_valid", bus.result_valid, 0);
        check("reset.timeout", bus.timeout, 0);
        check("reset.busy", bus.busy, 0);
        check("reset.n_starts", bus.n_starts, 0);
        check("reset.n_stops", bus.n_stops, 0);
        check("reset.n_timeouts", bus.n_timeouts, 0);

        // Stop pulse alone in IDLE must do nothing.
        bus.stop_pulse = 1'b1;
        step();
        bus.stop_pulse = 1'b0;
        step();
        check("idle_stop.busy", bus.busy, 0);
        check("idle_stop.n_stops", bus.n_stops, 0);

        run_one("basic25", 25, -1, -1, 1'b0, -1);
        run_one("no_stop", -1, -1, -1, 1'b0, -1);
        run_one("stop_at_max", TO, -1, -1, 1'b0, -1);
        run_one("stop_late121", TO + 1, -1, -1, 1'b0, -1);
        run_one("stop_min1", 1, -1, -1, 1'b0, -1);
        run_one("hold_start_costop", 60, -1, -1, 1'b1, 60 + 5);
        run_one("hold_start_last", 30, -1, -1, 1'b0, 30 + DEAD);
        run_one("drop50", -1, 50, -1, 1'b0, -1);
        run_one("drop_at_stop", 40, 40, -1, 1'b0, -1);
        run_one("drop_in_hold", 20, 28, -1, 1'b0, -1);
        run_one("clear_with_stop", 40, -1, 40, 1'b0, -1);
        run_one("clear_with_timeout", -1, -1, TO, 1'b0, -1);
        run_one("clear_with_start", 70, -1, 0, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            s  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 140));
            d  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 140)) : -1;
            c  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 140)) : -1;
            co = 1'($urandom_range(0, 1));
            n  = -1;
            if ($urandom_range(0, 1) == 1) begin
                n = ((s >= 1 && s <= TO) ? s : TO) + int'($urandom_range(1, DEAD));
            end
            run_one($sformatf("rand%0d", i), s, d, c, co, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdc_ctrl.md
Name: tdc_ctrl

Overview:
- Sequencer for the muon-lifetime time-to-digital measurement.
- Arms on an A·B coincidence pulse and counts clock cycles until a stop pulse from channel C or a timeout.
- Latches the interval, then enforces a dead time before re-arming.
- Sits between the coincidence/edge-detect logic and the display mux. It also keeps start/stop/timeout statistics for the display modes.

Parameters:
- CNT_WIDTH, 16, width of interval counter and result.
- TIMEOUT_CYCLES, 120, longest valid interval in clk cycles (1.2 us at 100 MHz); must be less than 2^CNT_WIDTH-1.
- DEAD_CYCLES, 16, cycles spent in HOLD after any result before re-arming; must be at least 1.
- STAT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  measurement enable; low forces IDLE.
- start_pulse  in  1  single-cycle coincidence event (A and B).
- stop_pulse  in  1  single-cycle rising edge of channel C.
- clear_stats  in  1  synchronous clear of statistics counters.
- result  out  CNT_WIDTH  last interval; all-ones after a timeout.
- result_valid  out  1  one-cycle strobe when result updates.
- timeout  out  1  sticky flag: last result was a timeout.
- busy  out  1  high in RUN or HOLD.
- n_starts  out  STAT_WIDTH  accepted starts.
- n_stops  out  STAT_WIDTH  valid measurements.
- n_timeouts  out  STAT_WIDTH  timeouts.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; the polarity and synchronicity are fixed.
- Reset values: state=IDLE, count=0, result=0, result_valid=0, timeout=0, busy=0, all stat counters 0.
- IDLE:
  - start_pulse with enable high, sampled at edge t → RUN at t+1, count=1, n_starts+1.
  - A stop_pulse in IDLE, including one coincident with start, is ignored.
- RUN: count increments by 1 each cycle. Count value at cycle t+d equals d.
  - stop_pulse while count=d, with 1 ≤ d ≤ TIMEOUT_CYCLES → next edge: result=d, result_valid=1 for one cycle, timeout=0, n_stops+1, state HOLD.
  - No stop while count=TIMEOUT_CYCLES → next edge: result={CNT_WIDTH{1'b1}}, result_valid=1, timeout=1, n_timeouts+1, state HOLD.
  - Stop in the same cycle as count=TIMEOUT_CYCLES counts as a valid measurement, not a timeout.
  - start_pulse in RUN is ignored (default build).
- HOLD: dead counter runs for DEAD_CYCLES cycles, then IDLE. start_pulse and stop_pulse are ignored in HOLD.
- enable low in any state → IDLE at next edge. A measurement in progress is discarded: no result_valid, no stat change. result and timeout keep their values.
- clear_stats: zeroes n_* at next edge. If it coincides with an increment, the clear wins.
- Stat counters saturate at all-ones and never wrap.
- result and timeout hold until the next result. result_valid is never high for two consecutive cycles.
- Latency: stop edge to result_valid is 1 cycle. Minimum reported interval is 1.

Optional Feature:
- Macro TDC_RETRIGGER_EN.
- Defined: start_pulse in RUN restarts the measurement. count=1, n_starts+1, and no result is issued for the abandoned start.
- Undefined: start_pulse in RUN is ignored.
- IDLE and HOLD behaviour is identical in both builds.

Decomposition:
- Package tdc_pkg holds: the state enum (IDLE, RUN, HOLD), the TDC_OVERFLOW all-ones constant function of CNT_WIDTH, and the default widths.
- One sub-module, sat_counter (parameterised width, inc and clr, saturating), instantiated three times for the statistics.
- FSM and interval counter stay in tdc_ctrl.

Test Plan:
- Reset, then start at cycle 10, stop at cycle 35 → result_valid at cycle 36, result=25, timeout=0, n_starts=1, n_stops=1, busy low again at cycle 52.
- Start with no stop → result=16'hFFFF, timeout=1, n_timeouts=1, result_valid exactly 120 cycles after RUN entry.
- Stop at count=120 → result=120, timeout=0. Stop at cycle 121 after start lands in HOLD or IDLE → ignored, stats unchanged.
- Start during HOLD, and start+stop in the same IDLE cycle → HOLD start ignored; the IDLE one enters RUN with n_starts+1 and the stop ignored.
- enable dropped at count=50 → IDLE next edge, no result_valid, result keeps its previous value. clear_stats coincident with a stop → n_stops=0.
- With TDC_RETRIGGER_EN: start at t, second start at t+40, stop at t+70 → result=30, n_starts=2, n_stops=1.
